// File: rtl/dma32_read_arbiter.sv
// dma32_read_arbiter: shares one DMA read path between two clients.
// Each burst is one control transfer followed by 'length' routed data beats.
// Build option: define DMA32_ARB_FIXED_PRIO_EN for fixed priority (client 0
// wins ties); leave it undefined for round-robin arbitration.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A valid source holds its payload stable until that edge. Client
// ctrl_ready is a one-cycle acceptance pulse, raised only in IDLE.
module dma32_read_arbiter (
  input  logic        clk,
  input  logic        rst,
  // client 0
  input  logic        c0_ctrl_valid,
  output logic        c0_ctrl_ready,
  input  logic [31:0] c0_ctrl_index,
  input  logic [31:0] c0_ctrl_length,
  input  logic [2:0]  c0_ctrl_size,
  input  logic [4:0]  c0_ctrl_user,
  output logic        c0_chnl_valid,
  output logic [31:0] c0_chnl_data,
  input  logic        c0_chnl_ready,
  // client 1
  input  logic        c1_ctrl_valid,
  output logic        c1_ctrl_ready,
  input  logic [31:0] c1_ctrl_index,
  input  logic [31:0] c1_ctrl_length,
  input  logic [2:0]  c1_ctrl_size,
  input  logic [4:0]  c1_ctrl_user,
  output logic        c1_chnl_valid,
  output logic [31:0] c1_chnl_data,
  input  logic        c1_chnl_ready,
  // shared DMA read path
  output logic        dma_read_ctrl_valid,
  output logic [31:0] dma_read_ctrl_data_index,
  output logic [31:0] dma_read_ctrl_data_length,
  output logic [2:0]  dma_read_ctrl_data_size,
  output logic [4:0]  dma_read_ctrl_data_user,
  input  logic        dma_read_ctrl_ready,
  input  logic        dma_read_chnl_valid,
  input  logic [31:0] dma_read_chnl_data,
  output logic        dma_read_chnl_ready,
  output logic [1:0]  grant,
  // debug: current FSM state (0=IDLE, 1=CTRL, 2=DATA)
  output logic [1:0]  dbg_state_o
);

  // ARB is folded into IDLE: the winner is picked and latched in one cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CTRL = 2'd1,
    S_DATA = 2'd2
  } state_e;

  state_e      state_q;
  logic [1:0]  grant_q;
  logic [31:0] cnt_q;
  logic        rr_q;         // 1: client 1 has priority on the next tie
  logic        ctrl_valid_q;
  logic [31:0] index_q;
  logic [31:0] length_q;
  logic [2:0]  size_q;
  logic [4:0]  user_q;

  logic any_req;
  logic pick1;
  logic accept;
  logic in_data;
  logic beat;

  // Arbitration: pick the winner among pending requests
  always_comb begin
    any_req = c0_ctrl_valid | c1_ctrl_valid;
`ifdef DMA32_ARB_FIXED_PRIO_EN
    pick1   = c1_ctrl_valid & ~c0_ctrl_valid;
`else
    pick1   = c1_ctrl_valid & (~c0_ctrl_valid | rr_q);
`endif
    // rst gating keeps the acceptance pulse low while reset is held
    accept        = rst & (state_q == S_IDLE) & any_req;
    c0_ctrl_ready = accept & ~pick1;
    c1_ctrl_ready = accept & pick1;
  end

  // Data routing: only the granted client sees beats, and only in DATA
  always_comb begin
    in_data             = (state_q == S_DATA);
    c0_chnl_valid       = in_data & grant_q[0] & dma_read_chnl_valid;
    c1_chnl_valid       = in_data & grant_q[1] & dma_read_chnl_valid;
    c0_chnl_data        = (in_data & grant_q[0]) ? dma_read_chnl_data : 32'd0;
    c1_chnl_data        = (in_data & grant_q[1]) ? dma_read_chnl_data : 32'd0;
    dma_read_chnl_ready = in_data & ((grant_q[0] & c0_chnl_ready) |
                                     (grant_q[1] & c1_chnl_ready));
    beat                = dma_read_chnl_valid & dma_read_chnl_ready;
  end

  // Burst FSM: IDLE latches the winner, CTRL issues the request, DATA counts beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'b00;
      cnt_q        <= 32'd0;
      rr_q         <= 1'b0;
      ctrl_valid_q <= 1'b0;
      index_q      <= 32'd0;
      length_q     <= 32'd0;
      size_q       <= 3'd0;
      user_q       <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            grant_q      <= pick1 ? 2'b10 : 2'b01;
            index_q      <= pick1 ? c1_ctrl_index  : c0_ctrl_index;
            length_q     <= pick1 ? c1_ctrl_length : c0_ctrl_length;
            size_q       <= pick1 ? c1_ctrl_size   : c0_ctrl_size;
            user_q       <= pick1 ? c1_ctrl_user   : c0_ctrl_user;
            ctrl_valid_q <= 1'b1;
            state_q      <= S_CTRL;
          end
        end
        S_CTRL: begin
          if (dma_read_ctrl_ready) begin
            ctrl_valid_q <= 1'b0;
            if (length_q == 32'd0) begin
              // empty burst: nothing to route, hand the turn over right away
              state_q <= S_IDLE;
              grant_q <= 2'b00;
              rr_q    <= grant_q[0];
            end else begin
              cnt_q   <= length_q;
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // cnt_q is at least 1 here, so the decrement never wraps
          if (beat) begin
            cnt_q <= cnt_q - 32'd1;
            if (cnt_q == 32'd1) begin
              state_q <= S_IDLE;
              grant_q <= 2'b00;
              rr_q    <= grant_q[0];
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign dma_read_ctrl_valid       = ctrl_valid_q;
  assign dma_read_ctrl_data_index  = index_q;
  assign dma_read_ctrl_data_length = length_q;
  assign dma_read_ctrl_data_size   = size_q;
  assign dma_read_ctrl_data_user   = user_q;
  assign grant                     = grant_q;
  assign dbg_state_o               = state_q;

endmodule

// File: tb/tb_dma32_read_arbiter.sv
// Bench for dma32_read_arbiter: directed bursts, a DMA responder model and a
// scoreboard monitor comparing acceptances, ctrl transfers and routed beats.
module tb_dma32_read_arbiter;

  logic        clk;
  logic        rst;
  logic        c0_ctrl_valid, c0_ctrl_ready, c0_chnl_valid, c0_chnl_ready;
  logic [31:0] c0_ctrl_index, c0_ctrl_length, c0_chnl_data;
  logic [2:0]  c0_ctrl_size;
  logic [4:0]  c0_ctrl_user;
  logic        c1_ctrl_valid, c1_ctrl_ready, c1_chnl_valid, c1_chnl_ready;
  logic [31:0] c1_ctrl_index, c1_ctrl_length, c1_chnl_data;
  logic [2:0]  c1_ctrl_size;
  logic [4:0]  c1_ctrl_user;
  logic        dma_read_ctrl_valid, dma_read_ctrl_ready;
  logic [31:0] dma_read_ctrl_data_index, dma_read_ctrl_data_length;
  logic [2:0]  dma_read_ctrl_data_size;
  logic [4:0]  dma_read_ctrl_data_user;
  logic        dma_read_chnl_valid, dma_read_chnl_ready;
  logic [31:0] dma_read_chnl_data;
  logic [1:0]  grant;
  logic [1:0]  dbg_state_o;

  dma32_read_arbiter dut (
    .clk(clk), .rst(rst),
    .c0_ctrl_valid(c0_ctrl_valid), .c0_ctrl_ready(c0_ctrl_ready),
    .c0_ctrl_index(c0_ctrl_index), .c0_ctrl_length(c0_ctrl_length),
    .c0_ctrl_size(c0_ctrl_size), .c0_ctrl_user(c0_ctrl_user),
    .c0_chnl_valid(c0_chnl_valid), .c0_chnl_data(c0_chnl_data),
    .c0_chnl_ready(c0_chnl_ready),
    .c1_ctrl_valid(c1_ctrl_valid), .c1_ctrl_ready(c1_ctrl_ready),
    .c1_ctrl_index(c1_ctrl_index), .c1_ctrl_length(c1_ctrl_length),
    .c1_ctrl_size(c1_ctrl_size), .c1_ctrl_user(c1_ctrl_user),
    .c1_chnl_valid(c1_chnl_valid), .c1_chnl_data(c1_chnl_data),
    .c1_chnl_ready(c1_chnl_ready),
    .dma_read_ctrl_valid(dma_read_ctrl_valid),
    .dma_read_ctrl_data_index(dma_read_ctrl_data_index),
    .dma_read_ctrl_data_length(dma_read_ctrl_data_length),
    .dma_read_ctrl_data_size(dma_read_ctrl_data_size),
    .dma_read_ctrl_data_user(dma_read_ctrl_data_user),
    .dma_read_ctrl_ready(dma_read_ctrl_ready),
    .dma_read_chnl_valid(dma_read_chnl_valid),
    .dma_read_chnl_data(dma_read_chnl_data),
    .dma_read_chnl_ready(dma_read_chnl_ready),
    .grant(grant),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [0:0]  exp_acc_q[$];   // client id expected to be accepted next
  logic [73:0] exp_ctrl_q[$];  // {grant, index, length, size, user}
  logic [31:0] exp_b0_q[$];
  logic [31:0] exp_b1_q[$];
  int tests = 0;
  int fails = 0;
  int beats0 = 0;
  int beats1 = 0;
  int stall = 0;
  logic stray = 1'b0;
  logic bp_on = 1'b0;

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // expectation for one burst: acceptance, ctrl transfer, first nb beats
  task automatic push_burst(input int c, input logic [31:0] idx, input logic [31:0] len,
                            input logic [2:0] sz, input logic [4:0] usr, input int nb);
    exp_acc_q.push_back(c[0]);
    exp_ctrl_q.push_back({(c == 0) ? 2'b01 : 2'b10, idx, len, sz, usr});
    for (int i = 0; i < nb; i++) begin
      if (c == 0) exp_b0_q.push_back(idx + i);
      else        exp_b1_q.push_back(idx + i);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic req(input int c, input logic [31:0] idx, input logic [31:0] len,
                     input logic [2:0] sz, input logic [4:0] usr);
    int n = 0;
    logic got = 1'b0;
    @(posedge clk); #1;
    if (c == 0) begin
      c0_ctrl_valid = 1'b1; c0_ctrl_index = idx; c0_ctrl_length = len;
      c0_ctrl_size = sz; c0_ctrl_user = usr;
    end else begin
      c1_ctrl_valid = 1'b1; c1_ctrl_index = idx; c1_ctrl_length = len;
      c1_ctrl_size = sz; c1_ctrl_user = usr;
    end
    while (!got && n < 200) begin
      @(negedge clk);
      got = (c == 0) ? c0_ctrl_ready : c1_ctrl_ready;
      n++;
    end
    if (!got) flag($sformatf("req_timeout client %0d", c));
    @(posedge clk); #1;
    if (c == 0) c0_ctrl_valid = 1'b0;
    else        c1_ctrl_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!(grant == 2'b00 && exp_acc_q.size() == 0 && exp_ctrl_q.size() == 0 &&
                 exp_b0_q.size() == 0 && exp_b1_q.size() == 0) && n < 400);
    if (n >= 400) flag("wait_idle_timeout");
  endtask

  // client 0 sink readiness: toggles every cycle under backpressure
  initial begin
    c0_chnl_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_on) c0_chnl_ready = ~c0_chnl_ready;
      else       c0_chnl_ready = 1'b1;
    end
  end

  // DMA responder: acks ctrl after 'stall' cycles, then streams index+i beats
  initial begin : dma_model
    int mode;
    int wait_n;
    logic [31:0] r_idx, r_len, beat_i;
    logic fire;
    mode = 0; wait_n = 0; r_idx = 0; r_len = 0; beat_i = 0; fire = 1'b0;
    dma_read_ctrl_ready = 1'b0;
    dma_read_chnl_valid = 1'b0;
    dma_read_chnl_data  = 32'd0;
    forever begin
      @(negedge clk);
      fire = dma_read_chnl_valid && dma_read_chnl_ready;
      @(posedge clk); #1;
      if (!rst) begin
        mode = 0;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0;
      end else begin
        case (mode)
          0: begin
            dma_read_ctrl_ready = 1'b0;
            dma_read_chnl_valid = stray;
            dma_read_chnl_data  = 32'hdead_beef;
            if (dma_read_ctrl_valid) begin
              r_idx = dma_read_ctrl_data_index;
              r_len = dma_read_ctrl_data_length;
              dma_read_chnl_valid = 1'b0;
              if (stall == 0) begin dma_read_ctrl_ready = 1'b1; mode = 2; end
              else begin wait_n = stall; mode = 1; end
            end
          end
          1: begin
            wait_n--;
            if (wait_n == 0) begin dma_read_ctrl_ready = 1'b1; mode = 2; end
          end
          2: begin
            dma_read_ctrl_ready = 1'b0;
            if (r_len == 0) mode = 0;
            else begin
              beat_i = 0;
              dma_read_chnl_valid = 1'b1;
              dma_read_chnl_data  = r_idx;
              mode = 3;
            end
          end
          3: begin
            if (fire) begin
              beat_i++;
              if (beat_i == r_len) begin dma_read_chnl_valid = 1'b0; mode = 0; end
              else dma_read_chnl_data = r_idx + beat_i;
            end
          end
          default: mode = 0;
        endcase
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (c0_ctrl_ready) begin
        if (exp_acc_q.size() == 0) flag("c0_accept_unexpected");
        else check("accept_client", 74'd0, {73'd0, exp_acc_q.pop_front()});
      end
      if (c1_ctrl_ready) begin
        if (exp_acc_q.size() == 0) flag("c1_accept_unexpected");
        else check("accept_client", 74'd1, {73'd0, exp_acc_q.pop_front()});
      end
      if (dma_read_ctrl_valid && dma_read_ctrl_ready) begin
        if (exp_ctrl_q.size() == 0) flag("ctrl_unexpected");
        else check("ctrl_grant_fields",
                   {grant, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
                    dma_read_ctrl_data_size, dma_read_ctrl_data_user},
                   exp_ctrl_q.pop_front());
      end
      if (c0_chnl_valid && c0_chnl_ready) begin
        beats0++;
        if (exp_b0_q.size() == 0) flag("c0_beat_unexpected");
        else check("c0_beat_data", {42'd0, c0_chnl_data}, {42'd0, exp_b0_q.pop_front()});
      end
      if (c1_chnl_valid && c1_chnl_ready) begin
        beats1++;
        if (exp_b1_q.size() == 0) flag("c1_beat_unexpected");
        else check("c1_beat_data", {42'd0, c1_chnl_data}, {42'd0, exp_b1_q.pop_front()});
      end
      if (bp_on && dma_read_chnl_valid) begin
        check("bp_ready_mirror", {73'd0, dma_read_chnl_ready}, {73'd0, c0_chnl_ready});
        check("bp_c1_valid_low", {73'd0, c1_chnl_valid}, 74'd0);
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int b;
    int n;
    rst = 1'b0;
    c0_ctrl_valid = 1'b1;  // a request held during reset must not be accepted
    c0_ctrl_index = 32'h55; c0_ctrl_length = 32'd1; c0_ctrl_size = 3'd0; c0_ctrl_user = 5'd0;
    c1_ctrl_valid = 1'b0;
    c1_ctrl_index = 32'd0; c1_ctrl_length = 32'd0; c1_ctrl_size = 3'd0; c1_ctrl_user = 5'd0;
    c1_chnl_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl_ready", {72'd0, c0_ctrl_ready, c1_ctrl_ready}, 74'd0);
    check("rst_grant", {72'd0, grant}, 74'd0);
    check("rst_state", {72'd0, dbg_state_o}, 74'd0);
    check("rst_ctrl_valid", {73'd0, dma_read_ctrl_valid}, 74'd0);
    check("rst_ctrl_fields", {2'b00, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
                              dma_read_ctrl_data_size, dma_read_ctrl_data_user}, 74'd0);
    check("rst_chnl_ready", {73'd0, dma_read_chnl_ready}, 74'd0);
    c0_ctrl_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;

    // stray beat while idle: neither consumed nor routed
    stray = 1'b1;
    repeat (2) @(negedge clk);
    check("stray_chnl_ready", {73'd0, dma_read_chnl_ready}, 74'd0);
    check("stray_routed", {72'd0, c0_chnl_valid, c1_chnl_valid}, 74'd0);
    stray = 1'b0;
    @(negedge clk);

    // single c0 burst, ctrl acked after a 2-cycle stall
    stall = 2;
    push_burst(0, 32'h100, 32'd4, 3'd2, 5'd3, 4);
    req(0, 32'h100, 32'd4, 3'd2, 5'd3);
    @(negedge clk);
    check("latency_ctrl_valid", {73'd0, dma_read_ctrl_valid}, 74'd1);
    check("latency_grant", {72'd0, grant}, 74'd1);
    wait_idle();
    check("single_end_grant", {72'd0, grant}, 74'd0);
    stall = 0;

    // zero-length burst from c1
    b = beats1;
    push_burst(1, 32'h400, 32'd0, 3'd1, 5'h1f, 0);
    req(1, 32'h400, 32'd0, 3'd1, 5'h1f);
    wait_idle();
    check("len0_no_beats", beats1 - b, 74'd0);
    check("len0_grant", {72'd0, grant}, 74'd0);

    // two rounds of simultaneous requests: 01, 10, 01, 10
    push_burst(0, 32'h200, 32'd2, 3'd2, 5'd1, 2);
    push_burst(1, 32'h300, 32'd1, 3'd2, 5'd2, 1);
    fork
      req(0, 32'h200, 32'd2, 3'd2, 5'd1);
      req(1, 32'h300, 32'd1, 3'd2, 5'd2);
    join
    wait_idle();
    push_burst(0, 32'h220, 32'd1, 3'd3, 5'd4, 1);
    push_burst(1, 32'h320, 32'd2, 3'd3, 5'd5, 2);
    fork
      req(0, 32'h220, 32'd1, 3'd3, 5'd4);
      req(1, 32'h320, 32'd2, 3'd3, 5'd5);
    join
    wait_idle();

    // c0 served last, then a tie: round-robin favours c1
    push_burst(0, 32'h800, 32'd1, 3'd2, 5'd6, 1);
    req(0, 32'h800, 32'd1, 3'd2, 5'd6);
    wait_idle();
`ifdef DMA32_ARB_FIXED_PRIO_EN
    push_burst(0, 32'h900, 32'd2, 3'd2, 5'd7, 2);
    push_burst(1, 32'ha00, 32'd1, 3'd2, 5'd8, 1);
`else
    push_burst(1, 32'ha00, 32'd1, 3'd2, 5'd8, 1);
    push_burst(0, 32'h900, 32'd2, 3'd2, 5'd7, 2);
`endif
    fork
      req(0, 32'h900, 32'd2, 3'd2, 5'd7);
      req(1, 32'ha00, 32'd1, 3'd2, 5'd8);
    join
    wait_idle();

    // backpressure: c0 sink toggles every cycle over 8 beats
    bp_on = 1'b1;
    b = beats0;
    push_burst(0, 32'h500, 32'd8, 3'd2, 5'd9, 8);
    req(0, 32'h500, 32'd8, 3'd2, 5'd9);
    wait_idle();
    bp_on = 1'b0;
    check("bp_beat_count", beats0 - b, 74'd8);

    // reset after beat 2 of 6 abandons the burst
    b = beats0;
    push_burst(0, 32'h600, 32'd6, 3'd2, 5'd10, 2);
    req(0, 32'h600, 32'd6, 3'd2, 5'd10);
    n = 0;
    while (beats0 < b + 2 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) flag("mid_burst_wait_timeout");
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_grant", {72'd0, grant}, 74'd0);
    check("midrst_chnl_valid", {72'd0, c0_chnl_valid, c1_chnl_valid}, 74'd0);
    check("midrst_chnl_data", {42'd0, c0_chnl_data}, 74'd0);
    check("midrst_chnl_ready", {73'd0, dma_read_chnl_ready}, 74'd0);
    check("midrst_ctrl_valid", {73'd0, dma_read_ctrl_valid}, 74'd0);
    check("midrst_state", {72'd0, dbg_state_o}, 74'd0);
    check("midrst_beats", beats0 - b, 74'd2);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // fresh c1 burst after reset
    push_burst(1, 32'h700, 32'd3, 3'd2, 5'd11, 3);
    req(1, 32'h700, 32'd3, 3'd2, 5'd11);
    wait_idle();
    check("final_grant", {72'd0, grant}, 74'd0);
    check("queues_drained", exp_acc_q.size() + exp_ctrl_q.size() +
                            exp_b0_q.size() + exp_b1_q.size(), 74'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dma32_read_arbiter.md
DMA32_READ_ARBITER -- requirements
Module: dma32_read_arbiter

Interface
REQ-001 SHALL have no parameters; all widths are fixed: index/length 32, size 3, user 5, data 32.
REQ-002 SHALL provide clk  input  1  sole clock, rising edge.
REQ-003 SHALL provide rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide, for client n in {0,1}, cN_ctrl_valid  input  1  read request valid.
REQ-005 SHALL provide, for client n, cN_ctrl_ready  output  1  request accepted (one-cycle pulse).
REQ-006 SHALL provide, for client n, the request fields, all inputs: cN_ctrl_index 32, cN_ctrl_length 32 (beats), cN_ctrl_size 3, cN_ctrl_user 5.
REQ-007 SHALL provide, for client n, cN_chnl_valid  output  1 and cN_chnl_data  output  32  routed read beat.
REQ-008 SHALL provide, for client n, cN_chnl_ready  input  1  client can accept a beat.
REQ-009 SHALL provide the shared DMA control outputs: dma_read_ctrl_valid 1, dma_read_ctrl_data_index 32, dma_read_ctrl_data_length 32, dma_read_ctrl_data_size 3, dma_read_ctrl_data_user 5.
REQ-010 SHALL provide the shared DMA inputs and output: dma_read_ctrl_ready in 1, dma_read_chnl_valid in 1, dma_read_chnl_data in 32, dma_read_chnl_ready out 1.
REQ-011 SHALL provide grant  output  2  one-hot owner of the DMA read path; 00 when idle.

Function
REQ-012 SHALL implement the FSM IDLE -> ARB -> CTRL -> DATA -> IDLE.
REQ-013 IDLE: when either cN_ctrl_valid=1, latch the winner's index, length, size and user.
- Same cycle: pulse that client's cN_ctrl_ready for one cycle and set grant.
- Next state: CTRL.
- ARB is a single-cycle bookkeeping state merged with IDLE; no cycle is spent in it.
REQ-014 Arbitration SHALL be round-robin: the client not served last wins a tie. After reset, client 0 wins the first tie.
REQ-015 CTRL: dma_read_ctrl_valid=1 with the latched fields held stable until dma_read_ctrl_ready=1.
- Request-to-dma_read_ctrl_valid latency: exactly 1 cycle.
REQ-016 On the CTRL handshake, load beat counter = latched length and go to DATA.
- If length=0: go straight to IDLE and clear grant.
REQ-017 DATA, combinational routing:
- granted cN_chnl_valid = dma_read_chnl_valid
- granted cN_chnl_data = dma_read_chnl_data
- dma_read_chnl_ready = granted cN_chnl_ready
- non-granted chnl_valid = 0
REQ-018 DATA: decrement the counter on each beat where dma_read_chnl_valid and ready are both 1. On the beat that brings it to 0: go to IDLE, clear grant, record the served client for round-robin.
REQ-019 Outside DATA: dma_read_chnl_ready=0 and all cN_chnl_valid=0. Beats arriving outside DATA are not consumed.
REQ-020 A new request SHALL be accepted no earlier than the cycle after returning to IDLE. Minimum gap between bursts: 1 idle cycle.
REQ-021 Client requests arriving during CTRL/DATA SHALL be held pending, with ready=0. They are not dropped.
REQ-022 Length SHALL be treated as unsigned 32-bit; the counter does not wrap.

Reset
REQ-023 rst=0 SHALL asynchronously force:
- state=IDLE, grant=00, counter=0, round-robin pointer to client 0
- all ctrl fields and cN_ctrl_ready=0, dma_read_ctrl_valid=0
REQ-024 Reset mid-burst SHALL abandon the burst; the routed combinational outputs drop to 0 with grant.

Configuration
REQ-025 Macro DMA32_ARB_FIXED_PRIO_EN SHALL select the arbitration policy.
- Defined: fixed priority, client 0 always wins ties.
- Undefined: round-robin per REQ-014.

Verification
REQ-026 Single request: c0 index=0x100, length=4 -> c0_ctrl_ready pulses; next cycle dma_read_ctrl_valid with index 0x100, length 4, grant=01; 4 beats routed to c0; grant=00.
REQ-027 Simultaneous c0/c1 requests, twice in a row -> grant order 01, 10, 01, 10. With DMA32_ARB_FIXED_PRIO_EN: 01 whenever both are pending.
REQ-028 length=0 from c1 -> one DMA ctrl handshake, no beats routed, back to IDLE.
REQ-029 Backpressure: c0_chnl_ready toggles every cycle with 8 beats -> dma_read_chnl_ready mirrors it; exactly 8 beats delivered; c1_chnl_valid stays 0.
REQ-030 rst asserted after beat 2 of 6 -> all outputs 0 immediately; a fresh c1 request after rst completes normally.
